// File: rtl/ex_execute_unit_pkg.sv
// ----------------------------------------------------------------------------
// ex_execute_unit_pkg
// Shared encodings for the MIPS execute stage: opcodes, funct codes, ALU op
// classes, 4-bit ALU control codes and operand-forwarding select codes, plus
// a helper that decides whether one pipeline stage may forward to a source.
// ----------------------------------------------------------------------------
package ex_execute_unit_pkg;

    // Opcodes
    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU op classes produced by the main decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_SLT   = 2'b11;

    // 4-bit ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Forwarding select codes
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // A stage may forward to a source only if it writes a non-zero register
    // equal to that source; $zero is hard-wired and never forwarded.
    function automatic logic fwd_hit(input logic       reg_write,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
        return reg_write && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/ex_execute_unit_alu.sv
// ----------------------------------------------------------------------------
// alu
// 32-bit combinational ALU. Add/sub wrap without overflow detection; shifts
// operate on b; unlisted control codes yield zero.
// Ports: a, b (operands); shamt (fixed shift amount); shift_var (use a[4:0]
//        as shift amount); alu_ctrl (4-bit code); result (out).
// ----------------------------------------------------------------------------
module alu
    import ex_execute_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic        shift_var,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] result
);

    logic [4:0] sh_amt_s;

    // Shift amount source: register operand for variable shifts, else shamt
    always_comb begin
        sh_amt_s = 5'd0;
        if (shift_var) begin
            sh_amt_s = a[4:0];
        end else begin
            sh_amt_s = shamt;
        end
    end

    // Operation select
    always_comb begin
        result = 32'd0;
        case (alu_ctrl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = b << sh_amt_s;
            ALU_SRL:  result = b >> sh_amt_s;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: result = (a < b) ? 32'd1 : 32'd0;
            ALU_SRA:  result = $unsigned($signed(b) >>> sh_amt_s);
            ALU_NOR:  result = ~(a | b);
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/ex_execute_unit_alu_control.sv
// ----------------------------------------------------------------------------
// alu_control
// Turns the ALU op class and funct field into a 4-bit ALU code. Variable
// shifts share codes with the fixed shifts; shift_var tells the ALU to take
// the shift amount from A[4:0] instead of shamt.
// Ports: alu_op, funct (in); alu_ctrl, shift_var (out).
// ----------------------------------------------------------------------------
module alu_control
    import ex_execute_unit_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       shift_var
);

    // Decode op class, falling back to funct for R-type
    always_comb begin
        alu_ctrl  = ALU_ADD;
        shift_var = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_ctrl = ALU_ADD;
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            ALU_OP_SLT: alu_ctrl = ALU_SLT;
            ALU_OP_FUNCT: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:          alu_ctrl = ALU_AND;
                    FN_OR:           alu_ctrl = ALU_OR;
                    FN_XOR:          alu_ctrl = ALU_XOR;
                    FN_NOR:          alu_ctrl = ALU_NOR;
                    FN_SLT:          alu_ctrl = ALU_SLT;
                    FN_SLTU:         alu_ctrl = ALU_SLTU;
                    FN_SLL:          alu_ctrl = ALU_SLL;
                    FN_SRL:          alu_ctrl = ALU_SRL;
                    FN_SRA:          alu_ctrl = ALU_SRA;
                    FN_SLLV: begin
                        alu_ctrl  = ALU_SLL;
                        shift_var = 1'b1;
                    end
                    FN_SRLV: begin
                        alu_ctrl  = ALU_SRL;
                        shift_var = 1'b1;
                    end
                    FN_SRAV: begin
                        alu_ctrl  = ALU_SRA;
                        shift_var = 1'b1;
                    end
                    // JALR and any unrecognised funct compute an address sum
                    default:         alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ex_execute_unit_fwd.sv
// ----------------------------------------------------------------------------
// forwarding_unit
// Picks the source of each ALU operand (rs -> A, rt -> B) from the register
// file, the EX/MEM stage or the MEM/WB stage. EX/MEM wins over MEM/WB since it
// holds the younger value.
// Ports: rs, rt (sources); mem_write_register/mem_reg_write and
//        wb_write_register/wb_reg_write (producers); forward_a/forward_b
//        (FWD_* select codes).
// ----------------------------------------------------------------------------
module forwarding_unit
    import ex_execute_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] mem_write_register,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_write_register,
    input  logic       wb_reg_write,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    // Operand A select with MEM-over-WB priority
    always_comb begin
        forward_a = FWD_REG;
        if (fwd_hit(mem_reg_write, mem_write_register, rs)) begin
            forward_a = FWD_MEM;
        end else if (fwd_hit(wb_reg_write, wb_write_register, rs)) begin
            forward_a = FWD_WB;
        end else begin
            forward_a = FWD_REG;
        end
    end

    // Operand B select with MEM-over-WB priority
    always_comb begin
        forward_b = FWD_REG;
        if (fwd_hit(mem_reg_write, mem_write_register, rt)) begin
            forward_b = FWD_MEM;
        end else if (fwd_hit(wb_reg_write, wb_write_register, rt)) begin
            forward_b = FWD_WB;
        end else begin
            forward_b = FWD_REG;
        end
    end

endmodule

// File: rtl/ex_execute_unit.sv
// ----------------------------------------------------------------------------
// ex_execute_unit
// MIPS execute stage between the ID/EX and EX/MEM pipeline registers. Purely
// combinational: operand forwarding, ALU decode and ALU, destination-register
// select, BEQ/BNE resolution with misprediction flag, JAL/JALR detection.
// clk and reset are present for pipeline uniformity and affect no output.
// Ports:
//   i_read_data_1/2, i_sign_extended_imm, i_function, i_opcode, i_rs/rt/rd,
//   i_next_pc              - ID/EX operands and fields
//   i_mem_* / i_wb_*       - forwarding sources from EX/MEM and MEM/WB
//   i_alu_src, i_alu_op, i_reg_dst, i_branch_prediction, control bits
//   o_alu_result, o_read_data_2 (store data), o_write_register,
//   o_branch_taken, o_mispredicted, o_pc_plus_4, o_is_jal, control pass-through
// ----------------------------------------------------------------------------
module ex_execute_unit
    import ex_execute_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_read_data_1,
    input  logic [31:0] i_read_data_2,
    input  logic [31:0] i_sign_extended_imm,
    input  logic [5:0]  i_function,
    input  logic [5:0]  i_opcode,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_next_pc,
    input  logic [4:0]  i_mem_write_register,
    input  logic        i_mem_reg_write,
    input  logic [31:0] i_mem_alu_result,
    input  logic [4:0]  i_wb_write_register,
    input  logic        i_wb_reg_write,
    input  logic [31:0] i_wb_write_data,
    input  logic        i_alu_src,
    input  logic [1:0]  i_alu_op,
    input  logic        i_reg_dst,
    input  logic        i_branch_prediction,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_mem_to_reg,
    input  logic        i_branch,
    output logic [31:0] o_alu_result,
    output logic [31:0] o_read_data_2,
    output logic [4:0]  o_write_register,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_mem_to_reg,
    output logic        o_branch,
    output logic        o_branch_taken,
    output logic        o_mispredicted,
    output logic [31:0] o_pc_plus_4,
    output logic        o_is_jal
);

    logic [1:0]  forward_a_s;
    logic [1:0]  forward_b_s;
    logic [31:0] operand_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] operand_b_s;
    logic [3:0]  alu_ctrl_s;
    logic        shift_var_s;

    // The stage holds no state; clk and reset are deliberately left idle.
    logic unused_s;
    assign unused_s = clk ^ reset;

    forwarding_unit u_forwarding_unit (
        .rs                 (i_rs),
        .rt                 (i_rt),
        .mem_write_register (i_mem_write_register),
        .mem_reg_write      (i_mem_reg_write),
        .wb_write_register  (i_wb_write_register),
        .wb_reg_write       (i_wb_reg_write),
        .forward_a          (forward_a_s),
        .forward_b          (forward_b_s)
    );

    // Forwarding mux for operand A
    always_comb begin
        operand_a_s = i_read_data_1;
        case (forward_a_s)
            FWD_MEM: operand_a_s = i_mem_alu_result;
            FWD_WB:  operand_a_s = i_wb_write_data;
            default: operand_a_s = i_read_data_1;
        endcase
    end

    // Forwarding mux for rt; this value is also the store data
    always_comb begin
        fwd_b_s = i_read_data_2;
        case (forward_b_s)
            FWD_MEM: fwd_b_s = i_mem_alu_result;
            FWD_WB:  fwd_b_s = i_wb_write_data;
            default: fwd_b_s = i_read_data_2;
        endcase
    end

    // ALU operand B: immediate or forwarded rt
    always_comb begin
        operand_b_s = fwd_b_s;
        if (i_alu_src) begin
            operand_b_s = i_sign_extended_imm;
        end else begin
            operand_b_s = fwd_b_s;
        end
    end

    alu_control u_alu_control (
        .alu_op    (i_alu_op),
        .funct     (i_function),
        .alu_ctrl  (alu_ctrl_s),
        .shift_var (shift_var_s)
    );

    alu u_alu (
        .a         (operand_a_s),
        .b         (operand_b_s),
        .shamt     (i_sign_extended_imm[10:6]),
        .shift_var (shift_var_s),
        .alu_ctrl  (alu_ctrl_s),
        .result    (o_alu_result)
    );

    // Destination register select
    always_comb begin
        o_write_register = i_rt;
        if (i_reg_dst) begin
            o_write_register = i_rd;
        end else begin
            o_write_register = i_rt;
        end
    end

    // Branch resolution compares forwarded rs/rt, never the immediate
    always_comb begin
        o_branch_taken = 1'b0;
        o_mispredicted = 1'b0;
        if (i_branch) begin
            o_branch_taken = ((i_opcode == OP_BEQ) && (operand_a_s == fwd_b_s)) ||
                             ((i_opcode == OP_BNE) && (operand_a_s != fwd_b_s));
            o_mispredicted = (o_branch_taken != i_branch_prediction);
        end else begin
            o_branch_taken = 1'b0;
            o_mispredicted = 1'b0;
        end
    end

    // Link-instruction detect and pass-through signals
    always_comb begin
        o_is_jal      = (i_opcode == OP_JAL) ||
                        ((i_opcode == OP_R_TYPE) && (i_function == FN_JALR));
        o_read_data_2 = fwd_b_s;
        o_pc_plus_4   = i_next_pc;
        o_reg_write   = i_reg_write;
        o_mem_read    = i_mem_read;
        o_mem_write   = i_mem_write;
        o_mem_to_reg  = i_mem_to_reg;
        o_branch      = i_branch;
    end

endmodule

// File: tb/tb_ex_execute_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_execute_unit
// Directed vectors with hand-computed expectations for the execute stage.
// ----------------------------------------------------------------------------
module tb_ex_execute_unit;

    logic        clk;
    logic        reset;
    logic [31:0] i_read_data_1;
    logic [31:0] i_read_data_2;
    logic [31:0] i_sign_extended_imm;
    logic [5:0]  i_function;
    logic [5:0]  i_opcode;
    logic [4:0]  i_rs;
    logic [4:0]  i_rt;
    logic [4:0]  i_rd;
    logic [31:0] i_next_pc;
    logic [4:0]  i_mem_write_register;
    logic        i_mem_reg_write;
    logic [31:0] i_mem_alu_result;
    logic [4:0]  i_wb_write_register;
    logic        i_wb_reg_write;
    logic [31:0] i_wb_write_data;
    logic        i_alu_src;
    logic [1:0]  i_alu_op;
    logic        i_reg_dst;
    logic        i_branch_prediction;
    logic        i_reg_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_to_reg;
    logic        i_branch;
    logic [31:0] o_alu_result;
    logic [31:0] o_read_data_2;
    logic [4:0]  o_write_register;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_mem_to_reg;
    logic        o_branch;
    logic        o_branch_taken;
    logic        o_mispredicted;
    logic [31:0] o_pc_plus_4;
    logic        o_is_jal;

    int checks_r   = 0;
    int failures_r = 0;

    ex_execute_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .i_read_data_1        (i_read_data_1),
        .i_read_data_2        (i_read_data_2),
        .i_sign_extended_imm  (i_sign_extended_imm),
        .i_function           (i_function),
        .i_opcode             (i_opcode),
        .i_rs                 (i_rs),
        .i_rt                 (i_rt),
        .i_rd                 (i_rd),
        .i_next_pc            (i_next_pc),
        .i_mem_write_register (i_mem_write_register),
        .i_mem_reg_write      (i_mem_reg_write),
        .i_mem_alu_result     (i_mem_alu_result),
        .i_wb_write_register  (i_wb_write_register),
        .i_wb_reg_write       (i_wb_reg_write),
        .i_wb_write_data      (i_wb_write_data),
        .i_alu_src            (i_alu_src),
        .i_alu_op             (i_alu_op),
        .i_reg_dst            (i_reg_dst),
        .i_branch_prediction  (i_branch_prediction),
        .i_reg_write          (i_reg_write),
        .i_mem_read           (i_mem_read),
        .i_mem_write          (i_mem_write),
        .i_mem_to_reg         (i_mem_to_reg),
        .i_branch             (i_branch),
        .o_alu_result         (o_alu_result),
        .o_read_data_2        (o_read_data_2),
        .o_write_register     (o_write_register),
        .o_reg_write          (o_reg_write),
        .o_mem_read           (o_mem_read),
        .o_mem_write          (o_mem_write),
        .o_mem_to_reg         (o_mem_to_reg),
        .o_branch             (o_branch),
        .o_branch_taken       (o_branch_taken),
        .o_mispredicted       (o_mispredicted),
        .o_pc_plus_4          (o_pc_plus_4),
        .o_is_jal             (o_is_jal)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (act !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Quiet idle inputs: no forwarding, ADD class, register operands
    task automatic clear_inputs();
        i_read_data_1        = 32'd0;
        i_read_data_2        = 32'd0;
        i_sign_extended_imm  = 32'd0;
        i_function           = 6'd0;
        i_opcode             = 6'd0;
        i_rs                 = 5'd0;
        i_rt                 = 5'd0;
        i_rd                 = 5'd0;
        i_next_pc            = 32'd0;
        i_mem_write_register = 5'd0;
        i_mem_reg_write      = 1'b0;
        i_mem_alu_result     = 32'd0;
        i_wb_write_register  = 5'd0;
        i_wb_reg_write       = 1'b0;
        i_wb_write_data      = 32'd0;
        i_alu_src            = 1'b0;
        i_alu_op             = 2'b00;
        i_reg_dst            = 1'b0;
        i_branch_prediction  = 1'b0;
        i_reg_write          = 1'b0;
        i_mem_read           = 1'b0;
        i_mem_write          = 1'b0;
        i_mem_to_reg         = 1'b0;
        i_branch             = 1'b0;
    endtask

    // Settle combinational outputs away from the clock edge
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // R-type ALU vector: A and B from the register file, funct and shamt-bearing imm
    task automatic rtype(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] exp);
        clear_inputs();
        reset               = 1'b1;
        i_alu_op            = 2'b10;
        i_function          = fn;
        i_read_data_1       = a;
        i_read_data_2       = b;
        i_sign_extended_imm = imm;
        settle();
        check_val(tag, o_alu_result, exp);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        settle();
        // Reset state: all-zero inputs give zero outputs
        check_val("rst_alu", o_alu_result, 32'd0);
        check_val("rst_wreg", {27'd0, o_write_register}, 32'd0);
        check_val("rst_flags", {30'd0, o_branch_taken, o_is_jal}, 32'd0);
        reset = 1'b1;

        // Forwarding priority
        clear_inputs();
        i_rs = 5'd5; i_rt = 5'd6; i_read_data_1 = 32'd50; i_read_data_2 = 32'd1;
        i_mem_write_register = 5'd5; i_mem_reg_write = 1'b1; i_mem_alu_result = 32'd100;
        i_wb_write_register = 5'd5; i_wb_reg_write = 1'b1; i_wb_write_data = 32'd200;
        settle();
        check_val("fwd_mem_prio", o_alu_result, 32'd101);
        i_mem_reg_write = 1'b0;
        settle();
        check_val("fwd_wb", o_alu_result, 32'd201);
        i_wb_reg_write = 1'b0;
        settle();
        check_val("fwd_none", o_alu_result, 32'd51);
        // Reset asserted mid-operation must change nothing
        i_mem_reg_write = 1'b1;
        reset = 1'b0;
        settle();
        check_val("rst_no_effect", o_alu_result, 32'd101);
        reset = 1'b1;

        // Register 0 never forwarded
        clear_inputs();
        i_rs = 5'd0; i_mem_write_register = 5'd0; i_mem_reg_write = 1'b1;
        i_mem_alu_result = 32'd100; i_wb_reg_write = 1'b1; i_wb_write_data = 32'd300;
        i_read_data_1 = 32'd7; i_alu_src = 1'b1; i_sign_extended_imm = 32'd3;
        settle();
        check_val("reg0_addi", o_alu_result, 32'd10);

        // R-type decode
        rtype("slt",  6'h2A, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1);
        rtype("sltu", 6'h2B, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        rtype("sub",  6'h22, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFE);
        rtype("nor_a", 6'h27, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h00000000);
        rtype("nor_b", 6'h27, 32'h00000000, 32'd1, 32'd0, 32'hFFFFFFFE);
        rtype("and",  6'h24, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1);
        rtype("or",   6'h25, 32'h0000F000, 32'd1, 32'd0, 32'h0000F001);
        rtype("xor",  6'h26, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFE);
        rtype("addu", 6'h21, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        rtype("sll",  6'h00, 32'd0, 32'd3, 32'h00000100, 32'h00000030);
        rtype("srl",  6'h02, 32'd0, 32'h80000000, 32'h00000100, 32'h08000000);
        rtype("sra",  6'h03, 32'd0, 32'h80000000, 32'h00000100, 32'hF8000000);
        rtype("srav", 6'h07, 32'h00000024, 32'h80000000, 32'd0, 32'hF8000000);
        rtype("sllv", 6'h04, 32'd8, 32'd1, 32'h000007C0, 32'h00000100);
        rtype("srlv", 6'h06, 32'd1, 32'h00000010, 32'd0, 32'h00000008);
        rtype("jalr_add", 6'h09, 32'd2, 32'd3, 32'd0, 32'd5);
        rtype("unk_add", 6'h3F, 32'd2, 32'd3, 32'd0, 32'd5);

        // Non-R-type classes
        clear_inputs();
        i_alu_op = 2'b01; i_read_data_1 = 32'd5; i_read_data_2 = 32'd7;
        settle();
        check_val("op_sub", o_alu_result, 32'hFFFFFFFE);
        i_alu_op = 2'b11; i_read_data_1 = 32'hFFFFFFFF; i_alu_src = 1'b1; i_sign_extended_imm = 32'd0;
        settle();
        check_val("op_slt", o_alu_result, 32'd1);

        // Branch resolution
        clear_inputs();
        i_branch = 1'b1; i_opcode = 6'b000100; i_read_data_1 = 32'd9; i_read_data_2 = 32'd9;
        i_alu_src = 1'b1; i_sign_extended_imm = 32'd77;
        settle();
        check_val("beq_taken", {31'd0, o_branch_taken}, 32'd1);
        check_val("beq_mispred", {31'd0, o_mispredicted}, 32'd1);
        i_branch_prediction = 1'b1;
        settle();
        check_val("beq_pred_ok", {31'd0, o_mispredicted}, 32'd0);
        i_branch_prediction = 1'b0; i_opcode = 6'b000101;
        settle();
        check_val("bne_eq_taken", {31'd0, o_branch_taken}, 32'd0);
        check_val("bne_eq_mispred", {31'd0, o_mispredicted}, 32'd0);
        i_read_data_2 = 32'd8;
        settle();
        check_val("bne_ne_taken", {31'd0, o_branch_taken}, 32'd1);
        i_read_data_2 = 32'd9; i_opcode = 6'b000100; i_branch = 1'b0;
        settle();
        check_val("nobr_flags", {30'd0, o_branch_taken, o_mispredicted}, 32'd0);
        check_val("nobr_passthru", {31'd0, o_branch}, 32'd0);

        // Store path with rt forwarded from WB
        clear_inputs();
        i_rs = 5'd3; i_rt = 5'd7; i_read_data_1 = 32'h100; i_read_data_2 = 32'h999;
        i_wb_write_register = 5'd7; i_wb_reg_write = 1'b1; i_wb_write_data = 32'h55;
        i_alu_src = 1'b1; i_sign_extended_imm = 32'd8; i_mem_write = 1'b1;
        settle();
        check_val("sw_data", o_read_data_2, 32'h55);
        check_val("sw_addr", o_alu_result, 32'h108);
        check_val("sw_memw", {31'd0, o_mem_write}, 32'd1);

        // JAL / JALR detection and write-register select
        clear_inputs();
        i_opcode = 6'b000011; i_next_pc = 32'h00400008; i_reg_dst = 1'b1; i_rd = 5'd31; i_rt = 5'd12;
        i_reg_write = 1'b1; i_mem_read = 1'b1; i_mem_to_reg = 1'b1;
        settle();
        check_val("jal_det", {31'd0, o_is_jal}, 32'd1);
        check_val("jal_pc4", o_pc_plus_4, 32'h00400008);
        check_val("jal_wreg", {27'd0, o_write_register}, 32'd31);
        check_val("ctl_passthru", {29'd0, o_reg_write, o_mem_read, o_mem_to_reg}, 32'd7);
        i_reg_dst = 1'b0;
        settle();
        check_val("rt_wreg", {27'd0, o_write_register}, 32'd12);
        i_opcode = 6'b000000; i_function = 6'b001001;
        settle();
        check_val("jalr_det", {31'd0, o_is_jal}, 32'd1);
        i_function = 6'h20;
        settle();
        check_val("add_not_jal", {31'd0, o_is_jal}, 32'd0);
        i_opcode = 6'b000100; i_function = 6'b001001;
        settle();
        check_val("beq_fn9_not_jal", {31'd0, o_is_jal}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
